// File: rtl/skew_dcache.sv
// Skewed-associative write-back data cache: per-way XOR/rotate index hash, LRU by global timestamp.
// Latency: hits complete combinationally in IDLE; a miss runs WB (dirty victim only), FILL_REQ, FILL_WAIT, then hits next cycle.
// Backpressure: processor holds its request until Dcache2proc_valid; memory response 0 is retried every cycle.
module skew_dcache #(
    parameter int WAYS = 4,
    parameter int SETS = 32,
    parameter int TS_W = 8,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      proc2Dcache_command,
    input  logic [XLEN-1:0] proc2Dcache_addr,
    input  logic [63:0]     proc2Dcache_data,
    output logic [63:0]     Dcache2proc_data,
    output logic            Dcache2proc_valid,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [1:0]      proc2mem_command,
    output logic [1:0]      proc2mem_size
);

    localparam int SW = $clog2(SETS);
    localparam int BW = XLEN - 3;
    localparam int WW = $clog2(WAYS);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] DOUBLE    = 2'd3;

    typedef enum logic [1:0] {IDLE, WB, FILL_REQ, FILL_WAIT} state_t;

    state_t state_q, state_d;

    logic [WAYS-1:0][SETS-1:0]           valid_q;
    logic [WAYS-1:0][SETS-1:0]           dirty_q;
    logic [WAYS-1:0][SETS-1:0][TS_W-1:0] ts_q;
    logic [BW-1:0]                       tag_q  [WAYS][SETS];
    logic [63:0]                         data_q [WAYS][SETS];
    logic [TS_W-1:0]                     gc_q;

    logic [WW-1:0] vic_way_q;
    logic [SW-1:0] vic_idx_q;
    logic [BW-1:0] miss_blk_q;
    logic [3:0]    pend_tag_q;

    logic [BW-1:0] req_blk;
    logic          addr_unused;
    logic          access;
    logic          is_store;
    logic [SW-1:0] idx_arr [WAYS];
    logic          hit;
    logic [WW-1:0] hit_way;
    logic          hit_vld;
    logic [WW-1:0] vic_way;
    logic [TS_W-1:0] best_ts;
    logic          vic_dirty;
    logic          fill_en;
    logic          touch;
    logic [WW-1:0] touch_way;
    logic [SW-1:0] touch_idx;

    logic [1:0]      mem_cmd;
    logic [XLEN-1:0] mem_addr;
    logic [63:0]     mem_data;

    // Way w uses low index bits XORed with the next SW bits rotated left by (w mod SW).
    function automatic logic [SW-1:0] hash_idx(input logic [2*SW-1:0] b, input int w);
        logic [SW-1:0]   hi;
        logic [2*SW-1:0] dbl;
        int              r;
        hi  = b[2*SW-1:SW];
        r   = w % SW;
        dbl = {hi, hi} << r;
        return b[SW-1:0] ^ dbl[2*SW-1:SW];
    endfunction

    assign req_blk     = proc2Dcache_addr[XLEN-1:3];
    assign addr_unused = ^proc2Dcache_addr[2:0];
    assign access      = (proc2Dcache_command != BUS_NONE);
    assign is_store    = (proc2Dcache_command == BUS_STORE);

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            idx_arr[w] = hash_idx(req_blk[2*SW-1:0], w);
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx_arr[w]] && (tag_q[w][idx_arr[w]] == req_blk)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Oldest timestamp wins (ties to lowest way), but any invalid way overrides, lowest first.
    always_comb begin
        vic_way = '0;
        best_ts = ts_q[0][idx_arr[0]];
        for (int w = 1; w < WAYS; w++) begin
            if (ts_q[w][idx_arr[w]] < best_ts) begin
                best_ts = ts_q[w][idx_arr[w]];
                vic_way = WW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx_arr[w]]) begin
                vic_way = WW'(w);
            end
        end
        vic_dirty = valid_q[vic_way][idx_arr[vic_way]] && dirty_q[vic_way][idx_arr[vic_way]];
    end

    assign hit_vld = (state_q == IDLE) && access && hit;

    always_comb begin
        state_d  = state_q;
        mem_cmd  = BUS_NONE;
        mem_addr = '0;
        mem_data = '0;
        fill_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !hit) begin
                    state_d = vic_dirty ? WB : FILL_REQ;
                end
            end
            WB: begin
                mem_cmd  = BUS_STORE;
                mem_addr = {tag_q[vic_way_q][vic_idx_q], 3'b000};
                mem_data = data_q[vic_way_q][vic_idx_q];
                if (mem2proc_response != 4'd0) begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_cmd  = BUS_LOAD;
                mem_addr = {miss_blk_q, 3'b000};
                if (mem2proc_response != 4'd0) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                // Tag 0 never names a real transaction, so it cannot complete a fill.
                if ((mem2proc_tag != 4'd0) && (mem2proc_tag == pend_tag_q)) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign touch     = fill_en || hit_vld;
    assign touch_way = fill_en ? vic_way_q : hit_way;
    assign touch_idx = fill_en ? vic_idx_q : idx_arr[hit_way];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            ts_q       <= '0;
            gc_q       <= '0;
            vic_way_q  <= '0;
            vic_idx_q  <= '0;
            miss_blk_q <= '0;
            pend_tag_q <= '0;
        end else begin
            if ((state_q == IDLE) && access && !hit) begin
                vic_way_q  <= vic_way;
                vic_idx_q  <= idx_arr[vic_way];
                miss_blk_q <= req_blk;
            end
            if ((state_q == FILL_REQ) && (mem2proc_response != 4'd0)) begin
                pend_tag_q <= mem2proc_response;
            end
            if (fill_en) begin
                valid_q[vic_way_q][vic_idx_q] <= 1'b1;
                dirty_q[vic_way_q][vic_idx_q] <= 1'b0;
            end
            if (hit_vld && is_store) begin
                dirty_q[hit_way][idx_arr[hit_way]] <= 1'b1;
            end
            if (touch) begin
                gc_q <= gc_q + TS_W'(1);
                // Counter wrap restarts every line's age from zero.
                if (gc_q == {TS_W{1'b1}}) begin
                    ts_q <= '0;
                end else begin
                    ts_q[touch_way][touch_idx] <= gc_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[vic_way_q][vic_idx_q]  <= miss_blk_q;
            data_q[vic_way_q][vic_idx_q] <= mem2proc_data;
        end else if (hit_vld && is_store) begin
            data_q[hit_way][idx_arr[hit_way]] <= proc2Dcache_data;
        end
    end

    assign Dcache2proc_valid = hit_vld;
    assign Dcache2proc_data  = hit_vld ? data_q[hit_way][idx_arr[hit_way]] : 64'd0;
    assign proc2mem_command  = mem_cmd;
    assign proc2mem_addr     = mem_addr;
    assign proc2mem_data     = mem_data;
    assign proc2mem_size     = DOUBLE;

endmodule

// File: doc/skew_dcache.md
SKEW_DCACHE -- requirements
Module: skew_dcache

Interface
REQ-001 The block SHALL have parameter WAYS, default 4, meaning the number of skewed ways (power of two, 2..8).
REQ-002 The block SHALL have parameter SETS, default 32, meaning lines per way (power of two, at least 2); SW = log2(SETS).
REQ-003 The block SHALL have parameter TS_W, default 8, meaning the width of the per-line LRU timestamp.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port proc2Dcache_command, input, 2 bits: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2.
REQ-007 The block SHALL have port proc2Dcache_addr, input, XLEN bits: byte address; bits [2:0] are ignored, so accesses are 8-byte block granular.
REQ-008 The block SHALL have port proc2Dcache_data, input, 64 bits: store data.
REQ-009 The block SHALL have port Dcache2proc_data, output, 64 bits: load data.
REQ-010 The block SHALL have port Dcache2proc_valid, output, 1 bit: the access completes this cycle.
REQ-011 The block SHALL have ports mem2proc_response (input, 4 bits), mem2proc_data (input, 64 bits) and mem2proc_tag (input, 4 bits): the memory reply.
REQ-012 The block SHALL have ports proc2mem_addr (output, XLEN bits), proc2mem_data (output, 64 bits), proc2mem_command (output, 2 bits) and proc2mem_size (output, MEM_SIZE, always DOUBLE): the memory request.

Function
REQ-013 The block address SHALL be B = addr[XLEN-1:3]; the stored tag SHALL be the full B.
REQ-014 The index for way w SHALL be B[SW-1:0] XOR rotl_SW(B[2SW-1:SW], w mod SW), where rotl_SW is a left rotate within SW bits.
REQ-015 Per line, the block SHALL hold valid, dirty, tag, 64-bit data and a TS_W-bit timestamp.
REQ-016 A hit SHALL occur when exactly the way w whose line at its hashed index is valid with tag equal to B matches; the fill policy guarantees at most one way matches.
REQ-017 The hit SHALL be combinational: in IDLE with command != BUS_NONE and a hit, Dcache2proc_valid=1 in the same cycle.
REQ-018 On a load hit, Dcache2proc_data SHALL equal the line data.
REQ-019 On a store hit, the block SHALL write proc2Dcache_data to the line at the next edge and set its dirty bit.
REQ-020 Every hit or fill SHALL set the line's timestamp to the global counter GC and increment GC.
REQ-021 When GC wraps from all-ones to 0, all timestamps SHALL clear to 0 on the same edge.
REQ-022 Victim selection, among the WAYS candidate slots, SHALL pick the lowest-numbered invalid way; otherwise the way with the smallest timestamp, ties to the lowest way.
REQ-023 The FSM SHALL have states IDLE, WB, FILL_REQ and FILL_WAIT.
REQ-024 IDLE SHALL go to WB on a miss with a dirty victim, to FILL_REQ on a miss with a clean or invalid victim, and stay in IDLE otherwise; the victim way and miss address are latched on the transition.
REQ-025 In WB, proc2mem_command SHALL be BUS_STORE with the victim tag<<3 and victim data; if mem2proc_response != 0 the FSM goes to FILL_REQ, otherwise it stays and retries.
REQ-026 In FILL_REQ, proc2mem_command SHALL be BUS_LOAD with addr B<<3; if mem2proc_response != 0 the block latches it as the pending tag and goes to FILL_WAIT, otherwise it retries.
REQ-027 In FILL_WAIT, when mem2proc_tag equals the pending tag, the block SHALL write the line (valid=1, dirty=0, tag=B, data=mem2proc_data, timestamp updated) and return to IDLE; the held request then hits on the following cycle.
REQ-028 Tag 0 arriving in FILL_WAIT SHALL be ignored.
REQ-029 proc2mem_command SHALL be BUS_NONE in IDLE and in FILL_WAIT.
REQ-030 Dcache2proc_valid SHALL be 0 outside IDLE.
REQ-031 The processor SHALL hold command, address and data stable until Dcache2proc_valid=1.
REQ-032 Only one miss SHALL be outstanding at a time.
REQ-033 proc2mem_addr[2:0] SHALL always be 0.

Reset
REQ-034 On reset, all valid, dirty and timestamp bits SHALL clear, GC=0, and the FSM SHALL go to IDLE; data and tag arrays need not reset.
REQ-035 During reset, the outputs SHALL be Dcache2proc_valid=0, Dcache2proc_data=0, proc2mem_command=BUS_NONE, proc2mem_addr=0 and proc2mem_data=0.
REQ-036 Reset asserted mid-miss SHALL abandon the miss, and later memory replies carrying the old tag SHALL be ignored.

Verification
REQ-037 Cold load 0x1234 with memory response 3 and then tag 3 carrying 0xDEADBEEFCAFEBABE -> exactly one BUS_LOAD at 0x1230; valid=1 with that data on the cycle after the tag.
REQ-038 Store 0x1234 of 0x1111 after the REQ-037 fill, then load 0x1234 -> both have valid=1 in the same cycle with no memory traffic; the load returns 0x1111.
REQ-039 With WAYS=2, SETS=2, cold loads 0x00, 0x18 and 0x20 (all index 0) -> the third load evicts block 0x00 (lowest timestamp); a reload of 0x00 misses.
REQ-040 As REQ-039 but storing 0xAA to 0x00 first -> BUS_STORE at 0x00 with data 0xAA precedes the BUS_LOAD at 0x20.
REQ-041 Memory response 0 for 3 cycles in FILL_REQ -> BUS_LOAD is re-issued each cycle; a reply with a non-matching tag in FILL_WAIT -> no fill.
REQ-042 Reset asserted in FILL_WAIT, then the old tag arrives -> the line stays invalid, the FSM stays in IDLE, and the outputs hold their REQ-035 values.
